// File: rtl/axi4_lite_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regs_if
// Brief    : AXI4-Lite bus bundle with master and slave views
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_slave_regs_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0]  AWADDR;
    logic [2:0]                AWPROT;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      WVALID;
    logic                      WREADY;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [ADDRESS_WIDTH-1:0]  ARADDR;
    logic [2:0]                ARPROT;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regs
// Brief    : AXI4-Lite subordinate with a byte-strobed register bank
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_regs #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    axi4_lite_slave_regs_if.slave            s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
    output logic                             wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]      wr_index
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS * BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] WS_COLLECT = 1'b0;
    localparam logic [0:0] WS_RESP    = 1'b1;
    localparam logic [1:0] RS_IDLE    = 2'd0;
    localparam logic [1:0] RS_LOOKUP  = 2'd1;
    localparam logic [1:0] RS_RESP    = 2'd2;

    logic [0:0]               wr_state_q, wr_state_d;
    logic [1:0]               rd_state_q, rd_state_d;
    logic                     awready_q, awready_d, wready_q, wready_d;
    logic                     aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [BYTES-1:0]         wstrb_q, wstrb_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic                     arready_q, arready_d;
    logic                     rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;
    logic                     wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]         wr_index_q, wr_index_d;
    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]    regs_d [NUM_REGS];

    logic             aw_hs, w_hs, ar_hs, commit;
    logic             aw_in_range, ar_in_range;
    logic [IDX_W-1:0] aw_index, ar_index;
    logic             unused_prot;

    assign aw_hs       = s_axi.AWVALID && awready_q;
    assign w_hs        = s_axi.WVALID && wready_q;
    assign ar_hs       = s_axi.ARVALID && arready_q;
    assign commit      = (wr_state_q == WS_COLLECT) && aw_full_q && w_full_q;
    assign aw_in_range = awaddr_q < ADDR_LIMIT;
    assign ar_in_range = araddr_q < ADDR_LIMIT;
    assign aw_index    = awaddr_q[LSB +: IDX_W];
    assign ar_index    = araddr_q[LSB +: IDX_W];
    assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_q <= WS_COLLECT;
            rd_state_q <= RS_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_pulse_q <= 1'b0;
            wr_index_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_index_q <= wr_index_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WS_COLLECT: if (aw_full_q && w_full_q) wr_state_d = WS_RESP;
            WS_RESP:    if (s_axi.BREADY) wr_state_d = WS_COLLECT;
            default:    wr_state_d = WS_COLLECT;
        endcase
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RS_IDLE:   if (ar_hs) rd_state_d = RS_LOOKUP;
            RS_LOOKUP: rd_state_d = RS_RESP;
            RS_RESP:   if (s_axi.RREADY) rd_state_d = RS_IDLE;
            default:   rd_state_d = RS_IDLE;
        endcase
    end

    always_comb begin
        awaddr_d  = aw_hs ? s_axi.AWADDR : awaddr_q;
        wdata_d   = w_hs ? s_axi.WDATA : wdata_q;
        wstrb_d   = w_hs ? s_axi.WSTRB : wstrb_q;
        aw_full_d = commit ? 1'b0 : (aw_full_q || aw_hs);
        w_full_d  = commit ? 1'b0 : (w_full_q || w_hs);
        // Each channel reopens only once its beat is consumed and no response is pending.
        awready_d = (wr_state_d == WS_COLLECT) && !aw_full_d;
        wready_d  = (wr_state_d == WS_COLLECT) && !w_full_d;

        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = 1'b0;
        wr_index_d = wr_index_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
            if (aw_in_range) begin
                for (int k = 0; k < BYTES; k++) begin
                    if (wstrb_q[k]) regs_d[aw_index][k*8 +: 8] = wdata_q[k*8 +: 8];
                end
                wr_pulse_d = 1'b1;
                wr_index_d = aw_index;
            end
        end else if (bvalid_q && s_axi.BREADY) begin
            bvalid_d = 1'b0;
        end

        araddr_d  = ar_hs ? s_axi.ARADDR : araddr_q;
        arready_d = (rd_state_d == RS_IDLE);
        rvalid_d  = (rd_state_d == RS_RESP);
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        // Sampling regs_q gives read-before-write against a commit on the same edge.
        if (rd_state_q == RS_LOOKUP) begin
            rdata_d = ar_in_range ? regs_q[ar_index] : '0;
            rresp_d = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;
    assign wr_index      = wr_index_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
endmodule
`default_nettype wire
